wb_ram_bridge: RTL
==================

Name: wb_ram_bridge

Overview:
- Wishbone B4 classic slave that acts as initiator on the banked DFFRAM macro port (EN, WE[3:0], Di, Do, A).
- Converts single bus cycles into registered RAM strobes and returns ack or err.
- Sits between the SoC interconnect and the 6K×32 RAM macro. The interconnect has already decoded the base address, so the bridge sees byte offsets only.

Parameters:
- DEPTH_WORDS, 6144, number of 32-bit words in the attached RAM.
- ADDR_W, 13, RAM word-address width; must satisfy 2**ADDR_W >= DEPTH_WORDS.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  request strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_sel_i  in  4  byte-lane enables.
- wb_adr_i  in  32  byte address (offset).
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  normal completion, one-cycle pulse.
- wb_err_o  out  1  error completion, one-cycle pulse.
- ram_en  out  1  RAM enable.
- ram_we  out  4  RAM byte write enables.
- ram_di  out  32  RAM write data.
- ram_a  out  ADDR_W  RAM word address.
- ram_do  in  32  RAM read data; valid the cycle after an EN=1, WE=0 strobe.

Behaviour:
- Reset, asynchronous on RESETn low:
  - state = IDLE.
  - All outputs 0, including wb_dat_o.
  - Any in-flight transaction is dropped and no response is issued.
- Request registers: addr, we, sel, data.
- State machine: IDLE, ACCESS, RDATA, RESP_ACK, RESP_ERR.
- IDLE: when wb_cyc_i & wb_stb_i, capture the request.
  - Error if wb_adr_i[1:0] != 0, or word index wb_adr_i[ADDR_W+1:2] >= DEPTH_WORDS → RESP_ERR.
  - Otherwise → ACCESS.
  - Address bits above ADDR_W+1 are ignored.
- ACCESS: drive the RAM from registered values only, with no combinational path from wb_* inputs to ram_*.
  - ram_a = captured word index; ram_di = captured data.
  - Write, sel != 0: ram_en = 1, ram_we = sel → RESP_ACK.
  - Write, sel == 0: ram_en = 0 (no-op) → RESP_ACK.
  - Read: ram_en = 1, ram_we = 0 → RDATA.
- RDATA: wb_dat_o <= ram_do at end of cycle → RESP_ACK.
  - Full 32 bits are returned regardless of sel.
- RESP_ACK / RESP_ERR: wb_ack_o or wb_err_o = 1 for exactly this cycle → IDLE.
  - ack and err are never both high.
- Latency, counting the cycle stb is sampled in IDLE as cycle 0:
  - Write ack in cycle 2.
  - Read ack in cycle 3.
  - Error in cycle 1.
- Back-to-back: the master may hold stb high with a new request in the cycle after ack; IDLE samples it then. Throughput is one write per 3 cycles and one read per 4 cycles.
- wb_dat_o holds its last read value until the next read completes; writes and errors do not change it.
- Abort: if wb_cyc_i = 0 in any non-IDLE state, go to IDLE next cycle with no ack/err.
  - A RAM strobe already being driven in ACCESS still completes.
  - An RDATA capture in progress is discarded (wb_dat_o unchanged).
- ram_en and ram_we are 0 in every state except ACCESS.
- ram_a and ram_di hold their last values outside ACCESS.

Decomposition:
- Package dffram_bus_pkg:
  - state enum.
  - Localparams: WORD_BYTES = 4, default DEPTH_WORDS = 6144, default ADDR_W = 13.
  - Function for the range/alignment check.
- No sub-module; the block is a single FSM plus request registers.

Test Plan:
- Write then read: write adr 0x0000_0010, sel 4'hF, dat 0xDEADBEEF.
  - Expect ram_en = 1, ram_we = F, ram_a = 4 in cycle 1, and ack in cycle 2.
  - A read of the same address returns 0xDEADBEEF with ack in cycle 3.
- Byte lanes: write 0x11223344 sel 4'hF, then 0x000000AA sel 4'b0001 at adr 0x20; read returns 0x112233AA.
  - A write with sel 0 produces no ram_en pulse, still acks, and leaves the data unchanged.
- Range and alignment:
  - adr 0x6000 (word 6144) → err in cycle 1, no ram_en.
  - adr 0x5FFC (word 6143) → ack.
  - adr 0x0002 → err.
  - wb_dat_o unchanged after each error.
- Back-to-back: hold cyc/stb high across 4 alternating writes and reads to adr 0x0, 0x4, 0x8, 0xC.
  - Exactly 4 single-cycle acks.
  - Read data matches the written data.
- Abort and reset:
  - Drop cyc in RDATA → no ack, next transaction normal.
  - Assert RESETn low in ACCESS → all outputs 0 immediately, state IDLE, no response after release.

Source files
------------

// File: rtl/dffram_bus_pkg.sv
// Shared types and helpers for the Wishbone-to-DFFRAM bridge.
`timescale 1ns/1ps
package dffram_bus_pkg;

    localparam int unsigned WORD_BYTES       = 4;
    localparam int unsigned BYTE_OFS_W       = $clog2(WORD_BYTES);
    localparam int unsigned SEL_W            = WORD_BYTES;
    localparam int unsigned DATA_W           = 8 * WORD_BYTES;
    localparam int unsigned BUS_ADDR_W       = 32;
    localparam int unsigned DFLT_DEPTH_WORDS = 6144;
    localparam int unsigned DFLT_ADDR_W      = 13;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCESS   = 3'd1,
        ST_RDATA    = 3'd2,
        ST_RESP_ACK = 3'd3,
        ST_RESP_ERR = 3'd4
    } state_e;

    // Misaligned byte offset, or word index (bits above addr_w ignored) past the RAM depth.
    function automatic logic req_is_bad(
        input logic [BUS_ADDR_W-1:0] adr,
        input int unsigned           addr_w,
        input int unsigned           depth
    );
        logic [BUS_ADDR_W-1:0] w_idx;
        w_idx = (adr >> BYTE_OFS_W) & ((BUS_ADDR_W'(1) << addr_w) - BUS_ADDR_W'(1));
        return (adr[BYTE_OFS_W-1:0] != '0) || (w_idx >= BUS_ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/wb_ram_bridge.sv
// Wishbone B4 classic slave driving a single-port DFFRAM macro with registered strobes.
// One bus cycle at a time; ack/err are single-cycle pulses.
`timescale 1ns/1ps
module wb_ram_bridge
    import dffram_bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DFLT_DEPTH_WORDS,
    parameter int unsigned ADDR_W      = DFLT_ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [SEL_W-1:0]      wb_sel_i,
    input  logic [BUS_ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  ram_en,
    output logic [SEL_W-1:0]      ram_we,
    output logic [DATA_W-1:0]     ram_di,
    output logic [ADDR_W-1:0]     ram_a,
    input  logic [DATA_W-1:0]     ram_do
);

    state_e              r_state;
    logic                r_we;
    logic                r_ack;
    logic                r_err;
    logic                r_ram_en;
    logic [SEL_W-1:0]    r_ram_we;
    logic [ADDR_W-1:0]   r_ram_a;
    logic [DATA_W-1:0]   r_ram_di;
    logic [DATA_W-1:0]   r_dat_o;

    state_e              w_state_nxt;
    logic                w_we_nxt;
    logic                w_ack_nxt;
    logic                w_err_nxt;
    logic                w_ram_en_nxt;
    logic [SEL_W-1:0]    w_ram_we_nxt;
    logic [ADDR_W-1:0]   w_ram_a_nxt;
    logic [DATA_W-1:0]   w_ram_di_nxt;
    logic [DATA_W-1:0]   w_dat_o_nxt;

    // State and all outputs are registered; the RAM strobe is loaded on entry to ACCESS.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_ram_en <= 1'b0;
            r_ram_we <= '0;
            r_ram_a  <= '0;
            r_ram_di <= '0;
            r_dat_o  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_we     <= w_we_nxt;
            r_ack    <= w_ack_nxt;
            r_err    <= w_err_nxt;
            r_ram_en <= w_ram_en_nxt;
            r_ram_we <= w_ram_we_nxt;
            r_ram_a  <= w_ram_a_nxt;
            r_ram_di <= w_ram_di_nxt;
            r_dat_o  <= w_dat_o_nxt;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        w_state_nxt  = r_state;
        w_we_nxt     = r_we;
        w_ack_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        w_ram_en_nxt = 1'b0;
        w_ram_we_nxt = '0;
        w_ram_a_nxt  = r_ram_a;
        w_ram_di_nxt = r_ram_di;
        w_dat_o_nxt  = r_dat_o;

        case (r_state)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    w_we_nxt = wb_we_i;
                    if (req_is_bad(wb_adr_i, ADDR_W, DEPTH_WORDS)) begin
                        w_state_nxt = ST_RESP_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt  = ST_ACCESS;
                        w_ram_a_nxt  = wb_adr_i[ADDR_W+BYTE_OFS_W-1:BYTE_OFS_W];
                        w_ram_di_nxt = wb_dat_i;
                        // A write with no lanes selected is acked without touching the RAM.
                        w_ram_en_nxt = !wb_we_i || (wb_sel_i != '0);
                        w_ram_we_nxt = wb_we_i ? wb_sel_i : '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_we) begin
                    w_state_nxt = ST_RESP_ACK;
                    w_ack_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP_ACK;
                    w_ack_nxt   = 1'b1;
                    w_dat_o_nxt = ram_do;
                end
            end
            ST_RESP_ACK, ST_RESP_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign wb_dat_o = r_dat_o;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign ram_en   = r_ram_en;
    assign ram_we   = r_ram_we;
    assign ram_a    = r_ram_a;
    assign ram_di   = r_ram_di;

endmodule
